// File: rtl/cache_line_fill_if.sv
// Miss, memory and fill channels of the cache line refill engine.
// master = refill engine, slave = miss source, memory and replacement stage.
interface cache_line_fill_if #(
    parameter int ADDR_W = 24,
    parameter int LINE_W = 145
);
    logic              miss_valid;
    logic [ADDR_W-1:0] miss_addr;
    logic              miss_ready;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [31:0]       mem_rsp_data;
    logic              mem_rsp_err;
    logic              fill_valid;
    logic [LINE_W-1:0] fill_line;
    logic [3:0]        fill_index;
    logic              fill_err;
    logic              fill_ready;
    logic              busy;

    modport master (
        input  miss_valid, miss_addr,
        output miss_ready,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        output fill_valid, fill_line, fill_index, fill_err,
        input  fill_ready,
        output busy
    );

    modport slave (
        output miss_valid, miss_addr,
        input  miss_ready,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_err,
        input  fill_valid, fill_line, fill_index, fill_err,
        output fill_ready,
        input  busy
    );
endinterface

// File: rtl/cache_line_fill.sv
// Cache line refill engine: fetches a 16-byte line as four 32-bit beats
// and presents {valid, tag, data} plus set index to the replacement stage.
module cache_line_fill #(
    parameter int ADDR_W = 24,
    parameter int BEATS  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cache_line_fill_if.master     bus
);
    localparam int TAG_W  = ADDR_W - 8;
    localparam int DATA_W = 32 * BEATS;
    localparam int LINE_W = 1 + TAG_W + DATA_W;
    localparam int BEAT_W = $clog2(BEATS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_PRESENT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [BEAT_W-1:0]   r_beat;
    logic [TAG_W-1:0]    r_tag;
    logic [3:0]          r_index;
    logic [DATA_W-1:0]   r_data;
    logic                r_err;
    logic [LINE_W-1:0]   r_line;
    logic [3:0]          r_fidx;
    logic                r_ferr;

    logic [DATA_W-1:0]   w_data_nxt;
    logic                w_err_nxt;
    logic                w_accept;
    logic                w_rsp;
    logic                w_last;
    logic                w_unused_ofs;

    // The line is always filled from word 0, so the byte offset is dropped.
    assign w_unused_ofs = ^bus.miss_addr[3:0];

    assign w_accept = (r_state == S_IDLE) && bus.miss_valid;
    assign w_rsp    = (r_state == S_WAIT) && bus.mem_rsp_valid;
    assign w_last   = (r_beat == BEAT_W'(BEATS - 1));
    assign w_err_nxt = r_err | bus.mem_rsp_err;

    always_comb begin
        w_data_nxt = r_data;
        w_data_nxt[32*r_beat +: 32] = bus.mem_rsp_data;
    end

    always_comb begin
        w_next            = r_state;
        bus.miss_ready    = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.fill_valid    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                bus.miss_ready = 1'b1;
                if (bus.miss_valid)
                    w_next = S_REQ;
            end
            S_REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready)
                    w_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_rsp_valid)
                    w_next = w_last ? S_PRESENT : S_REQ;
            end
            S_PRESENT: begin
                bus.fill_valid = 1'b1;
                if (bus.fill_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.mem_req_addr = {r_tag, r_index, r_beat, 2'b00};
    assign bus.fill_line    = r_line;
    assign bus.fill_index   = r_fidx;
    assign bus.fill_err     = r_ferr;
    assign bus.busy         = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Every beat is fetched even after an error to keep the bus balanced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat  <= '0;
            r_tag   <= '0;
            r_index <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_line  <= '0;
            r_fidx  <= '0;
            r_ferr  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tag   <= bus.miss_addr[ADDR_W-1:8];
                r_index <= bus.miss_addr[7:4];
                r_beat  <= '0;
                r_err   <= 1'b0;
            end
            if (w_rsp) begin
                r_data <= w_data_nxt;
                r_err  <= w_err_nxt;
                if (!w_last) begin
                    r_beat <= r_beat + 1'b1;
                end else begin
                    r_line <= {~w_err_nxt, r_tag, w_data_nxt};
                    r_fidx <= r_index;
                    r_ferr <= w_err_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_cache_line_fill.sv
// Directed bench for cache_line_fill: fills, backpressure, bus error,
// consumer stall, spurious responses and reset in mid-fill.
module tb_cache_line_fill;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   lat;

    cache_line_fill_if #(.ADDR_W(24), .LINE_W(145)) bus ();

    cache_line_fill dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [144:0] obs,
                       input logic [144:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_miss_ready"}, 145'(bus.miss_ready), 145'd1);
        chk({tag, "_req_valid"}, 145'(bus.mem_req_valid), 145'd0);
        chk({tag, "_fill_valid"}, 145'(bus.fill_valid), 145'd0);
        chk({tag, "_fill_line"}, bus.fill_line, 145'd0);
        chk({tag, "_fill_index"}, 145'(bus.fill_index), 145'd0);
        chk({tag, "_fill_err"}, 145'(bus.fill_err), 145'd0);
        chk({tag, "_busy"}, 145'(bus.busy), 145'd0);
    endtask

    // Runs one complete fill starting at a negedge with the engine in IDLE.
    task automatic run_fill(
        input string         tag,
        input logic [23:0]   addr,
        input logic [127:0]  data,
        input int            stall_beat,
        input int            stall_n,
        input bit            spur,
        input int            err_beat,
        input int            hold_n,
        input bit            pend,
        input logic [23:0]   pend_addr,
        input logic [144:0]  exp_line,
        input logic [3:0]    exp_idx,
        input bit            exp_err,
        input int            exp_lat
    );
        logic [23:0] ra;
        bus.miss_addr  = addr;
        bus.miss_valid = 1'b1;
        chk({tag, "_miss_ready"}, 145'(bus.miss_ready), 145'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.miss_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            ra = {addr[23:4], 2'(b), 2'b00};
            chk({tag, "_req_valid"}, 145'(bus.mem_req_valid), 145'd1);
            chk({tag, "_req_addr"}, 145'(bus.mem_req_addr), 145'(ra));
            if (b == stall_beat) begin
                for (int s = 0; s < stall_n; s++) begin
                    if (spur) begin
                        bus.mem_rsp_valid = 1'b1;
                        bus.mem_rsp_data  = 32'hDEADBEEF;
                        bus.mem_rsp_err   = 1'b1;
                    end
                    @(posedge clk);
                    lat++;
                    @(negedge clk);
                    bus.mem_rsp_valid = 1'b0;
                    bus.mem_rsp_err   = 1'b0;
                    chk({tag, "_stall_addr"}, 145'(bus.mem_req_addr),
                        145'(ra));
                    chk({tag, "_stall_valid"}, 145'(bus.mem_req_valid),
                        145'd1);
                end
            end
            bus.mem_req_ready = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            chk({tag, "_req_drop"}, 145'(bus.mem_req_valid), 145'd0);
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = data[32*b +: 32];
            bus.mem_rsp_err   = (b == err_beat);
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_err   = 1'b0;
        end
        chk({tag, "_fill_valid"}, 145'(bus.fill_valid), 145'd1);
        chk({tag, "_fill_line"}, bus.fill_line, exp_line);
        chk({tag, "_fill_index"}, 145'(bus.fill_index), 145'(exp_idx));
        chk({tag, "_fill_err"}, 145'(bus.fill_err), 145'(exp_err));
        chk({tag, "_latency"}, 145'(lat), 145'(exp_lat));
        if (pend) begin
            bus.miss_valid = 1'b1;
            bus.miss_addr  = pend_addr;
        end
        for (int h = 0; h < hold_n; h++) begin
            cyc();
            chk({tag, "_hold_valid"}, 145'(bus.fill_valid), 145'd1);
            chk({tag, "_hold_line"}, bus.fill_line, exp_line);
            chk({tag, "_hold_mready"}, 145'(bus.miss_ready), 145'd0);
        end
        bus.fill_ready = 1'b1;
        chk({tag, "_hs_mready"}, 145'(bus.miss_ready), 145'd0);
        cyc();
        bus.fill_ready = 1'b0;
        chk({tag, "_post_valid"}, 145'(bus.fill_valid), 145'd0);
        chk({tag, "_post_line"}, bus.fill_line, exp_line);
        chk({tag, "_post_busy"}, 145'(bus.busy), 145'd0);
        chk({tag, "_post_mready"}, 145'(bus.miss_ready), 145'd1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n             = 1'b0;
        bus.miss_valid    = 1'b0;
        bus.miss_addr     = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.mem_rsp_err   = 1'b0;
        bus.fill_ready    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outs("reset");
        rst_n = 1'b1;
        cyc();

        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hBADBAD00;
        bus.mem_rsp_err   = 1'b1;
        cyc();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_err   = 1'b0;
        chk("spur_idle_busy", 145'(bus.busy), 145'd0);
        chk("spur_idle_fill", 145'(bus.fill_valid), 145'd0);

        run_fill("basic", 24'hABCD5C,
                 128'h44444444_33333333_22222222_11111111,
                 -1, 0, 1'b0, -1, 0, 1'b0, 24'h0,
                 {1'b1, 16'hABCD,
                  128'h44444444_33333333_22222222_11111111},
                 4'h5, 1'b0, 9);

        run_fill("bp", 24'hABCD5C,
                 128'h44444444_33333333_22222222_11111111,
                 1, 5, 1'b1, -1, 0, 1'b0, 24'h0,
                 {1'b1, 16'hABCD,
                  128'h44444444_33333333_22222222_11111111},
                 4'h5, 1'b0, 14);

        run_fill("err", 24'h1234A7,
                 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,
                 -1, 0, 1'b0, 2, 0, 1'b0, 24'h0,
                 {1'b0, 16'h1234,
                  128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA},
                 4'hA, 1'b1, 9);

        run_fill("stall", 24'h5A5A30,
                 128'h0F0F0F0F_F0F0F0F0_01234567_89ABCDEF,
                 -1, 0, 1'b0, -1, 10, 1'b1, 24'hC0DE7F,
                 {1'b1, 16'h5A5A,
                  128'h0F0F0F0F_F0F0F0F0_01234567_89ABCDEF},
                 4'h3, 1'b0, 9);

        run_fill("pend", 24'hC0DE7F,
                 128'h00000004_00000003_00000002_00000001,
                 -1, 0, 1'b0, -1, 0, 1'b0, 24'h0,
                 {1'b1, 16'hC0DE,
                  128'h00000004_00000003_00000002_00000001},
                 4'h7, 1'b0, 9);

        bus.miss_addr  = 24'h777710;
        bus.miss_valid = 1'b1;
        cyc();
        bus.miss_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus.mem_req_ready = 1'b1;
            cyc();
            bus.mem_req_ready = 1'b0;
            if (b < 2) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = 32'h5555AAAA;
                cyc();
                bus.mem_rsp_valid = 1'b0;
            end
        end
        chk("rst_pre_busy", 145'(bus.busy), 145'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h99999999;
        cyc();
        bus.mem_rsp_valid = 1'b0;
        cyc();
        chk("rst_late_fill", 145'(bus.fill_valid), 145'd0);
        chk("rst_late_busy", 145'(bus.busy), 145'd0);
        chk("rst_late_req", 145'(bus.mem_req_valid), 145'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cache_line_fill.md
Name: cache_line_fill

Overview:
- Refill engine directly upstream of the 4-way FIFO replacement selector.
- On a cache miss it fetches one 16-byte line from memory as four 32-bit beats, then assembles the 145-bit line word {valid, tag[15:0], data[127:0]}.
- It presents that line plus the 4-bit set index to the replacement stage, which selects the victim way and writes the line.

Parameters:
- ADDR_W, 24, miss address width; bits [23:8] are the tag, [7:4] the index, [3:0] the byte offset.
- BEATS, 4, 32-bit beats per line; fixed at 4 because the 128-bit data field requires it.
- MAX_OUT, 1, outstanding memory requests; fixed at 1, one beat in flight.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- miss_valid  in  1  miss request present.
- miss_addr  in  ADDR_W  missing byte address.
- miss_ready  out  1  engine can accept a miss.
- mem_req_valid  out  1  beat read request.
- mem_req_addr  out  ADDR_W  beat address {tag, index, beat, 2'b00}.
- mem_req_ready  in  1  memory accepts request.
- mem_rsp_valid  in  1  beat data returned.
- mem_rsp_data  in  32  beat data.
- mem_rsp_err  in  1  bus error on this beat; qualified by mem_rsp_valid.
- fill_valid  out  1  assembled line available.
- fill_line  out  145  {valid, tag, data}; data word k occupies bits [32k+31:32k].
- fill_index  out  4  set index of the line.
- fill_err  out  1  line aborted by a bus error; qualified by fill_valid.
- fill_ready  in  1  replacement stage consumes the line.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = IDLE; beat counter = 0; captured tag, index and data = 0; err flag = 0.
  - Outputs: miss_ready=1, mem_req_valid=0, fill_valid=0, fill_line=0, fill_index=0, fill_err=0, busy=0.
- Reset asserted mid-fill abandons the line immediately. Any response still in flight after reset release is ignored while in IDLE.
- States: IDLE, REQ, WAIT, PRESENT.
- IDLE:
  - miss_ready=1.
  - On miss_valid & miss_ready: capture tag=miss_addr[23:8] and index=miss_addr[7:4]; set beat=0 and err=0; go to REQ.
  - The low offset bits are ignored; the line is always filled from word 0.
- REQ:
  - mem_req_valid=1, mem_req_addr={tag, index, beat[1:0], 2'b00}.
  - The address is held stable until mem_req_ready.
  - On mem_req_valid & mem_req_ready: go to WAIT; mem_req_valid deasserts the following cycle.
- WAIT:
  - On mem_rsp_valid: write mem_rsp_data into data word[beat]; OR mem_rsp_err into err.
  - If beat==3, go to PRESENT; otherwise beat+1, go to REQ.
  - A response arriving in any state other than WAIT is dropped.
  - There is no timeout; the engine waits indefinitely.
- An error does not shorten the fill: all 4 beats are always fetched so the memory protocol stays balanced.
- PRESENT:
  - fill_valid=1; fill_line={~err, tag, data}; fill_index=index; fill_err=err.
  - All fill outputs are held stable until fill_ready.
  - On fill_valid & fill_ready: go to IDLE; fill_valid drops the next cycle.
  - fill_line keeps its last value after the handshake, with valid bit unchanged.
- The valid bit is 1 only for an error-free line. An errored line is delivered with bit 144=0; the replacement stage ignores all-invalid lines.
- miss_ready=0 in REQ, WAIT and PRESENT. A miss asserted during a fill stalls; it is not queued.
- Minimum miss-to-fill_valid latency, with mem_req_ready=1 and one-cycle response: 9 cycles, i.e. 1 accept + 4×(REQ+WAIT).
- Back-to-back: the same cycle fill_ready completes in PRESENT, miss_ready is still 0. A new miss is accepted in the first cycle back in IDLE.
- Beat counter is 2 bits and wraps only via the explicit reset to 0 on miss accept.

Test Plan:
- Reset mid-WAIT, beat 2 → all outputs at reset values within the same cycle; a later mem_rsp_valid produces no fill.
- Basic fill: miss_addr=24'hABCD5C; responses 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444 → mem_req_addr sequence ABCD50/54/58/5C; fill_index=4'h5; fill_line={1'b1, 16'hABCD, 128'h44444444_33333333_22222222_11111111}; fill_valid asserted 9 cycles after accept.
- Memory backpressure: mem_req_ready held 0 for 5 cycles on beat 1 → mem_req_addr stays stable at beat 1; final line identical to the basic-fill case; latency +5 cycles.
- Bus error on beat 2 → all 4 requests still issued; fill_err=1; fill_line[144]=0; tag and data fields still filled.
- Consumer stall: fill_ready=0 for 10 cycles → fill_valid and fill_line stable throughout; a miss_valid asserted meanwhile sees miss_ready=0 and is accepted only after the fill handshake completes and the engine returns to IDLE.
- Spurious mem_rsp_valid in IDLE and REQ → ignored; data unchanged; beat counter unchanged.
